// File: rtl/word_byte_sequencer_pkg.sv
// Shared widths and FSM state type for the word-to-byte sequencer.
package word_byte_sequencer_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/word_byte_sequencer_splitter.sv
// Splits a 32-bit word into its four bytes; o1 is the most significant byte.
module splitter
    import word_byte_sequencer_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    output logic [BYTE_W-1:0] o1,
    output logic [BYTE_W-1:0] o2,
    output logic [BYTE_W-1:0] o3,
    output logic [BYTE_W-1:0] o4
);

    assign o1 = a[31:24];
    assign o2 = a[23:16];
    assign o3 = a[15:8];
    assign o4 = a[7:0];

endmodule

// File: rtl/word_byte_sequencer.sv
// Serializes one buffered 32-bit word into four bytes on a valid/ready stream.
// Optional even-parity output enabled by defining SEQ_PARITY_EN.
module word_byte_sequencer
    import word_byte_sequencer_pkg::*;
#(
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy
`ifdef SEQ_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    // Valid/ready: a transfer happens on a rising edge where both valid and
    // ready are high; valid never waits on ready, and the payload is held
    // stable while valid is high and ready is low.
    state_t            state_q, state_d;
    logic [WORD_W-1:0] wr_q, wr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic              in_hs;
    logic              out_hs;
    logic              at_last;
    logic [IDX_W-1:0]  sel;
    logic [BYTE_W-1:0] o1, o2, o3, o4;
    logic [BYTE_W-1:0] byte_sel;

    splitter u_splitter (
        .a  (wr_q),
        .o1 (o1),
        .o2 (o2),
        .o3 (o3),
        .o4 (o4)
    );

    assign at_last   = (idx_q == LAST_IDX);
    assign out_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign out_last  = out_valid & at_last;
    assign in_ready  = (state_q == IDLE) | ((state_q == SEND) & at_last & out_ready);
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    // LSB-first order walks the splitter outputs backwards: ~idx == 3 - idx.
    assign sel = (MSB_FIRST != 0) ? idx_q : ~idx_q;

    always_comb begin
        byte_sel = o1;
        case (sel)
            2'd0: byte_sel = o1;
            2'd1: byte_sel = o2;
            2'd2: byte_sel = o3;
            2'd3: byte_sel = o4;
            default: byte_sel = o1;
        endcase
    end

    assign out_data = out_valid ? byte_sel : '0;

`ifdef SEQ_PARITY_EN
    assign out_parity = out_valid & (^out_data);
`endif

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    state_d = SEND;
                    wr_d    = in_data;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (out_hs) begin
                    if (!at_last) begin
                        idx_d = idx_q + 2'd1;
                    end else if (in_hs) begin
                        wr_d  = in_data;
                        idx_d = '0;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_word_byte_sequencer.sv
// Directed bench for word_byte_sequencer: MSB-first and LSB-first instances
// share stimulus; a negedge monitor pops expected bytes from per-instance queues.
module tb_word_byte_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready, out_valid, out_last, busy;
    logic [7:0]  out_data;
    logic        l_in_ready, l_out_valid, l_out_last, l_busy;
    logic [7:0]  l_out_data;
`ifdef SEQ_PARITY_EN
    logic        out_parity, l_out_parity;
`endif

    // entry = {parity, last, data}
    logic [9:0] exp_q[$];
    logic [9:0] exp_l_q[$];

    int checks = 0;
    int errors = 0;

    word_byte_sequencer #(.MSB_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .busy(busy)
`ifdef SEQ_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    word_byte_sequencer #(.MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(l_in_ready), .out_valid(l_out_valid), .out_data(l_out_data),
        .out_last(l_out_last), .out_ready(out_ready), .busy(l_busy)
`ifdef SEQ_PARITY_EN
        , .out_parity(l_out_parity)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (act=timeout req=finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: act=%0h req=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // push the first n expected bytes of w for both byte orders
    task automatic push_word(input logic [31:0] w, input int n);
        logic [7:0] b [4];
        b[0] = w[31:24]; b[1] = w[23:16]; b[2] = w[15:8]; b[3] = w[7:0];
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({^b[k], (k == 3), b[k]});
            exp_l_q.push_back({^b[3-k], (k == 3), b[3-k]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("msb_unexpected_byte", {24'h0, out_data}, 32'hffff_ffff);
            end else begin
                e = exp_q.pop_front();
                check("msb_data", {24'h0, out_data}, {24'h0, e[7:0]});
                check("msb_last", {31'h0, out_last}, {31'h0, e[8]});
`ifdef SEQ_PARITY_EN
                check("msb_parity", {31'h0, out_parity}, {31'h0, e[9]});
`endif
            end
        end
        if (rst_n && l_out_valid && out_ready) begin
            if (exp_l_q.size() == 0) begin
                check("lsb_unexpected_byte", {24'h0, l_out_data}, 32'hffff_ffff);
            end else begin
                e = exp_l_q.pop_front();
                check("lsb_data", {24'h0, l_out_data}, {24'h0, e[7:0]});
                check("lsb_last", {31'h0, l_out_last}, {31'h0, e[8]});
`ifdef SEQ_PARITY_EN
                check("lsb_parity", {31'h0, l_out_parity}, {31'h0, e[9]});
`endif
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
        check({tag, "_out_data"}, {24'h0, out_data}, 32'h0);
        check({tag, "_out_last"}, {31'h0, out_last}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
        check({tag, "_lsb_out_valid"}, {31'h0, l_out_valid}, 32'h0);
`ifdef SEQ_PARITY_EN
        check({tag, "_out_parity"}, {31'h0, out_parity}, 32'h0);
`endif
    endtask

    // send one full word with out_ready=1 and wait for it to drain
    task automatic send_single(input logic [31:0] w);
        in_valid  = 1'b1;
        in_data   = w;
        out_ready = 1'b1;
        push_word(w, 4);
        tick();
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            check("single_busy", {31'h0, busy}, 32'h1);
            tick();
        end
        check("single_busy_fall", {31'h0, busy}, 32'h0);
        check("single_out_valid_fall", {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        #1;
        check_idle("reset");
        #20;
        rst_n = 1'b1;
        tick();

        // basic MSB/LSB order
        send_single(32'hD2484BF0);

        // back-to-back words with in_valid held
        in_valid  = 1'b1;
        in_data   = 32'h11223344;
        out_ready = 1'b1;
        push_word(32'h11223344, 4);
        tick();
        in_data = 32'hAABBCCDD;
        push_word(32'hAABBCCDD, 4);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("b2b_out_valid", {31'h0, out_valid}, 32'h1);
            check("b2b_in_ready", {31'h0, in_ready}, {31'h0, (i == 3 || i == 7)});
            if (i == 3) begin
                tick();
                in_valid = 1'b0;
                in_data  = 32'h0;
            end
        end
        tick();
        check("b2b_busy_fall", {31'h0, busy}, 32'h0);

        // stall while 0x48 is shown
        in_valid  = 1'b1;
        in_data   = 32'hD2484BF0;
        push_word(32'hD2484BF0, 4);
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_data", {24'h0, out_data}, 32'h48);
            check("stall_last", {31'h0, out_last}, 32'h0);
            check("stall_lsb_data", {24'h0, l_out_data}, 32'h4B);
            check("stall_in_ready", {31'h0, in_ready}, 32'h0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_resume", {24'h0, out_data}, 32'h48);
        repeat (3) tick();
        check("stall_busy_fall", {31'h0, busy}, 32'h0);

        // reset mid-word after byte 0x48
        in_valid = 1'b1;
        in_data  = 32'hD2484BF0;
        push_word(32'hD2484BF0, 2);
        tick();
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("midreset");
        #20;
        rst_n = 1'b1;
        tick();
        check_idle("post_reset");
        tick();
        check("post_reset_no_partial", {31'h0, out_valid}, 32'h0);
        send_single(32'h01020304);

        // parity vector (also exercised as plain data without the macro)
        send_single(32'h07000103);

        repeat (2) tick();
        check("msb_queue_empty", exp_q.size(), 32'h0);
        check("lsb_queue_empty", exp_l_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
